mult_div_seq: RTL and testbench

Iterative sequencer for the HI/LO multiply/divide resource. It accepts one MULT or DIV request at a time from the control unit's MULT_LOAD/DIV_LOAD states. It runs a shift-add multiply or a restoring divide over WIDTH iterations and writes the result into HI/LO. It then reports completion, or a divide-by-zero, for the control unit to route to its DIVZERO exception path.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_datapath.sv | 109 ++++++++++
 rtl/mult_div_seq.sv | 116 +++++++++++
 tb/tb_mult_div_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Signed (MIPS) semantics are selected by defining MULT_DIV_SIGNED_EN.
package mult_div_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } md_state_e;

endpackage

// File: rtl/mult_div_datapath.sv
// Shift-add multiply / restoring divide datapath driven by per-state strobes.
// MULT_DIV_SIGNED_EN adds operand magnitude and result sign correction.
module mult_div_datapath
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld_op,
    input  logic             start_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ld_mag,
    input  logic             calc,
    input  logic             fix,
    input  logic             op_div,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             dvsr_zero_c
);

    localparam int unsigned AW = WIDTH + 2;

    // prod_hi doubles as remainder, prod_lo as multiplier then quotient
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [AW-1:0]    add_res;

    // Shared WIDTH+1 adder; in DIV the top bit is the no-borrow flag
    always_comb begin
        add_a   = op_div ? {prod_hi, prod_lo[WIDTH-1]} : {1'b0, prod_hi};
        add_b   = op_div ? ~{1'b0, opnd} : {1'b0, opnd};
        add_res = AW'(add_a) + AW'(add_b) + AW'(op_div);
    end

    assign dvsr_zero_c = (opnd == '0);
    assign res_hi      = prod_hi;
    assign res_lo      = prod_lo;

`ifdef MULT_DIV_SIGNED_EN
    logic                 neg_lo;
    logic                 neg_hi;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     lo_neg;
    logic [WIDTH-1:0]     hi_neg;
    logic [WIDTH-1:0]     lo_abs;
    logic [WIDTH-1:0]     opnd_abs;

    assign prod_neg = -{prod_hi, prod_lo};
    assign lo_neg   = -prod_lo;
    assign hi_neg   = -prod_hi;
    assign lo_abs   = prod_lo[WIDTH-1] ? lo_neg : prod_lo;
    assign opnd_abs = opnd[WIDTH-1] ? -opnd : opnd;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_hi <= '0;
            prod_lo <= '0;
            opnd    <= '0;
`ifdef MULT_DIV_SIGNED_EN
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
`endif
        end else if (ld_op) begin
            prod_hi <= '0;
            prod_lo <= (start_op == MD_OP_DIV) ? a : b;
            opnd    <= (start_op == MD_OP_DIV) ? b : a;
        end else if (ld_mag) begin
            prod_hi <= '0;
`ifdef MULT_DIV_SIGNED_EN
            prod_lo <= lo_abs;
            opnd    <= opnd_abs;
            neg_lo  <= prod_lo[WIDTH-1] ^ opnd[WIDTH-1];
            neg_hi  <= prod_lo[WIDTH-1];
`endif
        end else if (calc) begin
            if (op_div) begin
                if (add_res[AW-1]) begin
                    prod_hi <= add_res[WIDTH-1:0];
                    prod_lo <= {prod_lo[WIDTH-2:0], 1'b1};
                end else begin
                    prod_hi <= {prod_hi[WIDTH-2:0], prod_lo[WIDTH-1]};
                    prod_lo <= {prod_lo[WIDTH-2:0], 1'b0};
                end
            end else if (prod_lo[0]) begin
                {prod_hi, prod_lo} <= {add_res[WIDTH:0], prod_lo[WIDTH-1:1]};
            end else begin
                {prod_hi, prod_lo} <= {1'b0, prod_hi, prod_lo[WIDTH-1:1]};
            end
        end else if (fix) begin
`ifdef MULT_DIV_SIGNED_EN
            if (op_div) begin
                if (neg_lo) prod_lo <= lo_neg;
                if (neg_hi) prod_hi <= hi_neg;
            end else if (neg_lo) begin
                {prod_hi, prod_lo} <= prod_neg;
            end
`else
            {prod_hi, prod_lo} <= {prod_hi, prod_lo};
`endif
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, result registers.
// Define MULT_DIV_SIGNED_EN for signed MIPS MULT/DIV semantics.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e        state;
    md_state_e        next_state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic             div0_q;
    logic             ld_op_c;
    logic             ld_mag_c;
    logic             calc_c;
    logic             fix_c;
    logic [WIDTH-1:0] dp_hi;
    logic [WIDTH-1:0] dp_lo;
    logic             dvsr_zero_c;

    mult_div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock       (clock),
        .reset       (reset),
        .ld_op       (ld_op_c),
        .start_op    (op),
        .a           (a),
        .b           (b),
        .ld_mag      (ld_mag_c),
        .calc        (calc_c),
        .fix         (fix_c),
        .op_div      (op_q),
        .res_hi      (dp_hi),
        .res_lo      (dp_lo),
        .dvsr_zero_c (dvsr_zero_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and per-state datapath strobes
    always_comb begin
        next_state = state;
        ld_op_c    = 1'b0;
        ld_mag_c   = 1'b0;
        calc_c     = 1'b0;
        fix_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ld_op_c    = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                ld_mag_c   = 1'b1;
                next_state = (op_q == MD_OP_DIV && dvsr_zero_c) ? DONE : CALC;
            end
            CALC: begin
                calc_c = 1'b1;
                if (cnt == '0) next_state = FIX;
            end
            FIX: begin
                fix_c      = 1'b1;
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            op_q   <= MD_OP_MULT;
            div0_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (ld_op_c)  op_q <= op;
            if (ld_mag_c) begin
                cnt    <= CNT_W'(WIDTH - 1);
                div0_q <= (op_q == MD_OP_DIV) && dvsr_zero_c;
            end
            if (calc_c)   cnt <= cnt - CNT_W'(1);
            busy <= (next_state != IDLE);
            done <= (state == DONE);
            div0 <= (state == DONE) && div0_q;
            // A divide-by-zero leaves HI/LO untouched
            if (state == DONE && !div0_q) begin
                hi <= dp_hi;
                lo <= dp_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq; expectations follow MULT_DIV_SIGNED_EN.
module tb_mult_div_seq;
    import mult_div_pkg::*;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int nbusy   = 0;
    bit seen;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mult_div_seq #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Drive one request; start is held across exactly one rising edge
    task automatic issue(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit expect_it, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ed, input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (expect_it) begin
            e.hi = eh; e.lo = el; e.div0 = ed; e.start_cyc = cyc; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0 && !busy) return;
        end
        n_total++;
        $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done with hi=0x%08h lo=0x%08h, required no pulse", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("div0", 32'(div0), 32'(mon_e.div0));
                check("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
            end
        end else if (div0) begin
            n_total++;
            $display("FAIL div0_alone: got div0=1 done=0, required div0 only with done");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div0", 32'(div0), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        issue(MD_OP_MULT, 32'd7, 32'd6, 1, 32'h0, 32'h2A, 1'b0, 35);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (busy) nbusy++;
            if (sb.size() == 0 && !busy) break;
        end
        check("busy_cycles", 32'(nbusy), 32'd35);

`ifdef MULT_DIV_SIGNED_EN
        issue(MD_OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 32'h1, 1'b0, 35);
        drain();
        issue(MD_OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 1'b0, 35);
        drain();
`else
        issue(MD_OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h1, 1'b0, 35);
        drain();
        issue(MD_OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'h4, 32'hFFFFFFF1, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'h1, 32'h7FFFFFFC, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0, 1'b0, 35);
        drain();
`endif
        // 629 = 34*18 + 17 seeds HI=0x11, LO=0x22 ahead of the divide-by-zero
        issue(MD_OP_DIV, 32'd629, 32'd18, 1, 32'h11, 32'h22, 1'b0, 35);
        drain();
        issue(MD_OP_DIV, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1'b1, 2);
        drain();

        // Start while busy is dropped; a start in the done cycle is taken
        issue(MD_OP_MULT, 32'h10000, 32'h10000, 1, 32'h1, 32'h0, 1'b0, 35);
        repeat (9) @(negedge clock);
        #1;
        issue(MD_OP_MULT, 32'd9, 32'd9, 0, '0, '0, 1'b0, 0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_total++;
            $display("FAIL done_wait: got no done in 60 cycles, required done");
        end
        issue(MD_OP_MULT, 32'd3, 32'd5, 1, 32'h0, 32'd15, 1'b0, 35);
        drain();

        // Reset mid-divide aborts without a done pulse
        issue(MD_OP_DIV, 32'd100, 32'd7, 0, '0, '0, 1'b0, 0);
        repeat (19) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_div0", 32'(div0), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (45) @(negedge clock);
        #1;
        issue(MD_OP_MULT, 32'd3, 32'd4, 1, 32'h0, 32'd12, 1'b0, 35);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
